ex_stage: RTL and testbench

//  Execute stage of the MIPS_CPU pipeline, directly downstream of ID.
//  - Consumes ID outputs (op, regaData, regbData, regcWr, regcAddr) through a valid/ready handshake.
//  - Computes the ALU result and holds it in a registered EX/MEM output slot for the MEM/WB stage.
//  - Detects signed overflow; shifts are optionally multi-cycle (serial).

---
 rtl/ex_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage -- execute stage of the MIPS_CPU pipeline, directly downstream of ID.
//
// Accepts one decoded instruction per cycle over a valid/ready handshake,
// computes the ALU result (with signed overflow detection for ADD/ADDI/SUB),
// and holds it in a single registered EX/MEM output slot until MEM/WB takes it.
// The slot may be refilled in the same cycle it drains, giving 1/cycle
// throughput when downstream is always ready.
//
// Configuration macro: EX_SERIAL_SHIFT_EN
//   undefined : SLL/SRL/SRA use a single-cycle barrel shifter (1-cycle latency).
//   defined   : SLL/SRL/SRA with sa>0 run serially, one bit per cycle, through
//               a SHIFT state (latency sa+1, in_ready low while shifting).
//
// Opcode encoding mirrors the CMD_* codes of MIPS.vh (OP_W wide).
//
// Ports
//   clk, rst                    clock (rising edge); synchronous active-high reset
//   in_valid / in_ready         input handshake from ID
//   op, regaData, regbData      operation and operands (sa in regbData[4:0])
//   regcWr, regcAddr            destination write request / register
//   out_valid / out_ready       output slot handshake to MEM/WB
//   regcWr_o, regcAddr_o        final write enable / destination register
//   regcData_o, ovf_o           ALU result / signed overflow flag
// ----------------------------------------------------------------------------
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] regaData,
    input  logic [DATA_W-1:0] regbData,
    input  logic              regcWr,
    input  logic [ADDR_W-1:0] regcAddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              regcWr_o,
    output logic [ADDR_W-1:0] regcAddr_o,
    output logic [DATA_W-1:0] regcData_o,
    output logic              ovf_o
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [OP_W-1:0] CMD_NONE = OP_W'(0);
    localparam logic [OP_W-1:0] CMD_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] CMD_ADDI = OP_W'(2);
    localparam logic [OP_W-1:0] CMD_SUB  = OP_W'(3);
    localparam logic [OP_W-1:0] CMD_AND  = OP_W'(4);
    localparam logic [OP_W-1:0] CMD_ANDI = OP_W'(5);
    localparam logic [OP_W-1:0] CMD_OR   = OP_W'(6);
    localparam logic [OP_W-1:0] CMD_ORI  = OP_W'(7);
    localparam logic [OP_W-1:0] CMD_XOR  = OP_W'(8);
    localparam logic [OP_W-1:0] CMD_XORI = OP_W'(9);
    localparam logic [OP_W-1:0] CMD_SLL  = OP_W'(10);
    localparam logic [OP_W-1:0] CMD_SRL  = OP_W'(11);
    localparam logic [OP_W-1:0] CMD_SRA  = OP_W'(12);
    localparam logic [OP_W-1:0] CMD_LUI  = OP_W'(13);

    logic [SH_W-1:0]   sa;
    logic [DATA_W-1:0] aluData;
    logic              aluOvf;
    logic              aluKnown;
    logic              aluWr;

    logic              slotFree;
    logic              accept;
    logic              loadAlu;

    logic              outValid_q, outValid_d;
    logic              regcWr_q,   regcWr_d;
    logic [ADDR_W-1:0] regcAddr_q, regcAddr_d;
    logic [DATA_W-1:0] regcData_q, regcData_d;
    logic              ovf_q,      ovf_d;

    assign sa       = regbData[SH_W-1:0];
    assign slotFree = ~outValid_q | out_ready;

    // Overflow: same-sign operands (ADD) or opposite-sign operands (SUB)
    // whose result sign differs from operand A.
    always_comb begin
        aluData  = '0;
        aluOvf   = 1'b0;
        aluKnown = 1'b1;
        case (op)
            CMD_ADD, CMD_ADDI: begin
                aluData = regaData + regbData;
                aluOvf  = (regaData[DATA_W-1] == regbData[DATA_W-1]) &&
                          (aluData[DATA_W-1] != regaData[DATA_W-1]);
            end
            CMD_SUB: begin
                aluData = regaData - regbData;
                aluOvf  = (regaData[DATA_W-1] != regbData[DATA_W-1]) &&
                          (aluData[DATA_W-1] != regaData[DATA_W-1]);
            end
            CMD_AND, CMD_ANDI: aluData = regaData & regbData;
            CMD_OR,  CMD_ORI:  aluData = regaData | regbData;
            CMD_XOR, CMD_XORI: aluData = regaData ^ regbData;
            CMD_LUI:           aluData = regaData << 16;
`ifdef EX_SERIAL_SHIFT_EN
            // Only reached directly when sa==0; nonzero shifts go serial.
            CMD_SLL, CMD_SRL, CMD_SRA: aluData = regaData;
`else
            CMD_SLL: aluData = regaData << sa;
            CMD_SRL: aluData = regaData >> sa;
            CMD_SRA: aluData = $unsigned($signed(regaData) >>> sa);
`endif
            CMD_NONE: aluKnown = 1'b0;
            default:  aluKnown = 1'b0;
        endcase
        aluWr = aluKnown & regcWr & ~aluOvf & (regcAddr != '0);
    end

`ifdef EX_SERIAL_SHIFT_EN
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [1:0] KIND_SLL = 2'd0;
    localparam logic [1:0] KIND_SRL = 2'd1;
    localparam logic [1:0] KIND_SRA = 2'd2;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shReg_q, shReg_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [1:0]        shKind_q, shKind_d;
    logic              shWr_q, shWr_d;
    logic [ADDR_W-1:0] shAddr_q, shAddr_d;
    logic [DATA_W-1:0] shStep;
    logic [DATA_W-1:0] shResult;
    logic              isShift;
    logic              startShift;
    logic              shiftDone;

    assign isShift    = (op == CMD_SLL) || (op == CMD_SRL) || (op == CMD_SRA);
    assign in_ready   = (state_q == IDLE) & slotFree;
    assign accept     = in_valid & in_ready;
    assign startShift = accept & isShift & (sa != '0);
    assign loadAlu    = accept & ~startShift;

    always_comb begin
        case (shKind_q)
            KIND_SLL: shStep = {shReg_q[DATA_W-2:0], 1'b0};
            KIND_SRL: shStep = {1'b0, shReg_q[DATA_W-1:1]};
            default:  shStep = {shReg_q[DATA_W-1], shReg_q[DATA_W-1:1]};
        endcase
    end

    // The final bit step and the slot load happen in the same cycle, so a
    // shift by sa spends exactly sa cycles in SHIFT. If the slot is busy the
    // last step is still taken and the engine parks at count 0.
    always_comb begin
        state_d   = state_q;
        shReg_d   = shReg_q;
        cnt_d     = cnt_q;
        shKind_d  = shKind_q;
        shWr_d    = shWr_q;
        shAddr_d  = shAddr_q;
        shiftDone = 1'b0;
        shResult  = (cnt_q == '0) ? shReg_q : shStep;
        case (state_q)
            IDLE: begin
                if (startShift) begin
                    state_d  = SHIFT;
                    shReg_d  = regaData;
                    cnt_d    = sa;
                    shKind_d = (op == CMD_SLL) ? KIND_SLL :
                               (op == CMD_SRL) ? KIND_SRL : KIND_SRA;
                    shWr_d   = regcWr & (regcAddr != '0);
                    shAddr_d = regcAddr;
                end
            end
            SHIFT: begin
                if (cnt_q > SH_W'(1)) begin
                    shReg_d = shStep;
                    cnt_d   = cnt_q - SH_W'(1);
                end else if (slotFree) begin
                    shiftDone = 1'b1;
                    state_d   = IDLE;
                end else begin
                    shReg_d = shResult;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shReg_q  <= '0;
            cnt_q    <= '0;
            shKind_q <= KIND_SLL;
            shWr_q   <= 1'b0;
            shAddr_q <= '0;
        end else begin
            state_q  <= state_d;
            shReg_q  <= shReg_d;
            cnt_q    <= cnt_d;
            shKind_q <= shKind_d;
            shWr_q   <= shWr_d;
            shAddr_q <= shAddr_d;
        end
    end
`else
    assign in_ready = slotFree;
    assign accept   = in_valid & in_ready;
    assign loadAlu  = accept;
`endif

    // Output slot: drains on out_ready, and a new result overrides the drain
    // so the slot can refill in the cycle it empties.
    always_comb begin
        outValid_d = outValid_q;
        regcWr_d   = regcWr_q;
        regcAddr_d = regcAddr_q;
        regcData_d = regcData_q;
        ovf_d      = ovf_q;
        if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
        if (loadAlu) begin
            outValid_d = 1'b1;
            regcWr_d   = aluWr;
            regcAddr_d = regcAddr;
            regcData_d = aluData;
            ovf_d      = aluOvf;
        end
`ifdef EX_SERIAL_SHIFT_EN
        if (shiftDone) begin
            outValid_d = 1'b1;
            regcWr_d   = shWr_q;
            regcAddr_d = shAddr_q;
            regcData_d = shResult;
            ovf_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            regcWr_q   <= 1'b0;
            regcAddr_q <= '0;
            regcData_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            outValid_q <= outValid_d;
            regcWr_q   <= regcWr_d;
            regcAddr_q <= regcAddr_d;
            regcData_q <= regcData_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid  = outValid_q;
    assign regcWr_o   = regcWr_q;
    assign regcAddr_o = regcAddr_q;
    assign regcData_o = regcData_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage -- scoreboard testbench for ex_stage.
//
// A driver issues directed and random instructions; each accepted one is
// turned into an expected beat by a reference model working from plain
// arithmetic and pushed into a queue together with the cycle at which it
// should first become visible. A monitor checks out_valid, in_ready and the
// output fields every cycle against the head of that queue and pops it when
// the beat is consumed. Works with or without EX_SERIAL_SHIFT_EN.
// ----------------------------------------------------------------------------
module tb_ex_stage;

    localparam logic [4:0] C_NONE = 5'd0;
    localparam logic [4:0] C_ADD  = 5'd1;
    localparam logic [4:0] C_ADDI = 5'd2;
    localparam logic [4:0] C_SUB  = 5'd3;
    localparam logic [4:0] C_AND  = 5'd4;
    localparam logic [4:0] C_ANDI = 5'd5;
    localparam logic [4:0] C_OR   = 5'd6;
    localparam logic [4:0] C_ORI  = 5'd7;
    localparam logic [4:0] C_XOR  = 5'd8;
    localparam logic [4:0] C_XORI = 5'd9;
    localparam logic [4:0] C_SLL  = 5'd10;
    localparam logic [4:0] C_SRL  = 5'd11;
    localparam logic [4:0] C_SRA  = 5'd12;
    localparam logic [4:0] C_LUI  = 5'd13;

`ifdef EX_SERIAL_SHIFT_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] regaData = '0;
    logic [31:0] regbData = '0;
    logic        regcWr = 1'b0;
    logic [4:0]  regcAddr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        regcWr_o;
    logic [4:0]  regcAddr_o;
    logic [31:0] regcData_o;
    logic        ovf_o;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(32), .ADDR_W(5), .OP_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .regaData   (regaData),
        .regbData   (regbData),
        .regcWr     (regcWr),
        .regcAddr   (regcAddr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .regcWr_o   (regcWr_o),
        .regcAddr_o (regcAddr_o),
        .regcData_o (regcData_o),
        .ovf_o      (ovf_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic [4:0]  addr;
        logic        ovf;
        int          acc;
        int          due;
        bit          serialShift;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   lastDrain = -100;
    bit   randomReady = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    // Reference model: result from the instruction's arithmetic meaning.
    function automatic exp_t model(logic [4:0] o, logic [31:0] a, logic [31:0] b,
                                   logic w, logic [4:0] ad, int acc);
        exp_t        e;
        longint      s;
        int          sh;
        bit          known;
        logic [31:0] ones;
        ones  = '1;
        e.data = '0;
        e.ovf  = 1'b0;
        known  = 1'b1;
        sh     = int'(b[4:0]);
        case (o)
            C_ADD, C_ADDI: begin
                s = longint'($signed(a)) + longint'($signed(b));
                e.data = a + b;
                e.ovf  = (s > MAX_S) || (s < MIN_S);
            end
            C_SUB: begin
                s = longint'($signed(a)) - longint'($signed(b));
                e.data = a - b;
                e.ovf  = (s > MAX_S) || (s < MIN_S);
            end
            C_AND, C_ANDI: e.data = a & b;
            C_OR,  C_ORI:  e.data = a | b;
            C_XOR, C_XORI: e.data = a ^ b;
            C_SLL: e.data = a << sh;
            C_SRL: e.data = a >> sh;
            C_SRA: e.data = a[31] ? ((a >> sh) | ~(ones >> sh)) : (a >> sh);
            C_LUI: e.data = a * 32'd65536;
            default: known = 1'b0;
        endcase
        e.wr   = known && w && !e.ovf && (ad != 5'd0);
        e.addr = ad;
        e.acc  = acc;
        e.serialShift = SERIAL && (o == C_SLL || o == C_SRL || o == C_SRA) && (sh > 0);
        e.due  = acc + (e.serialShift ? sh + 1 : 1);
        return e;
    endfunction

    task automatic driveCycle(input bit iv, input logic [4:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic w, input logic [4:0] ad,
                              input bit ordy, output bit accepted);
        @(negedge clk);
        in_valid  = iv;
        op        = o;
        regaData  = a;
        regbData  = b;
        regcWr    = w;
        regcAddr  = ad;
        out_ready = ordy;
        #1;
        accepted = iv && (in_ready === 1'b1);
        if (accepted) sbq.push_back(model(o, a, b, w, ad, cycle));
    endtask

    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic w, input logic [4:0] ad, input int holdLow);
        bit acc;
        bit ordy;
        int k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 200) begin
            ordy = (k < holdLow) ? 1'b0 :
                   (randomReady ? ($urandom_range(0, 3) != 0) : 1'b1);
            driveCycle(1'b1, o, a, b, w, ad, ordy, acc);
            k++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("[TB] FAIL accept_timeout: op %0d not accepted within %0d cycles", o, k);
        end
    endtask

    task automatic idleCycles(input int n, input bit ordy);
        bit dummy;
        for (int i = 0; i < n; i++) driveCycle(1'b0, op, regaData, regbData, regcWr, regcAddr, ordy, dummy);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_regcWr_o", 32'(regcWr_o), 32'd0);
        checkOutput("rst_regcAddr_o", 32'(regcAddr_o), 32'd0);
        checkOutput("rst_regcData_o", regcData_o, 32'd0);
        checkOutput("rst_ovf_o", 32'(ovf_o), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] randData();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: expected visibility of the head beat is its own due cycle or
    // the cycle after the previous beat drained, whichever is later.
    initial begin : monitor
        bit expValid;
        bit pend;
        int due;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                sbq.delete();
                lastDrain = cycle;
            end else begin
                expValid = 1'b0;
                if (sbq.size() > 0) begin
                    due = (sbq[0].due > lastDrain + 1) ? sbq[0].due : lastDrain + 1;
                    expValid = (cycle >= due);
                end
                pend = 1'b0;
                if (sbq.size() > 0) begin
                    if (sbq[$].serialShift && sbq[$].acc < cycle && !(sbq.size() == 1 && expValid))
                        pend = 1'b1;
                end
                checkOutput("in_ready", 32'(in_ready), 32'(!pend && (!expValid || out_ready)));
                checkOutput("out_valid", 32'(out_valid), 32'(expValid));
                if (expValid && out_valid === 1'b1) begin
                    checkOutput("regcData_o", regcData_o, sbq[0].data);
                    checkOutput("regcWr_o", 32'(regcWr_o), 32'(sbq[0].wr));
                    checkOutput("regcAddr_o", 32'(regcAddr_o), 32'(sbq[0].addr));
                    checkOutput("ovf_o", 32'(ovf_o), 32'(sbq[0].ovf));
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        lastDrain = cycle;
                    end
                end
            end
        end
    end

    initial begin : driver
        logic [4:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic        w;
        logic [4:0]  ad;
        int          k;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        pulseReset();

        randomReady = 1'b0;
        applyStimulus(C_ADD, 32'd5, 32'd7, 1'b1, 5'd3, 0);
        applyStimulus(C_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd4, 0);
        applyStimulus(C_SUB, 32'h8000_0000, 32'd1, 1'b1, 5'd5, 0);
        applyStimulus(C_ORI, 32'h0000_00F0, 32'h0000_000F, 1'b1, 5'd0, 0);
        applyStimulus(C_LUI, 32'h0000_1234, 32'd0, 1'b1, 5'd6, 0);
        applyStimulus(C_NONE, 32'h1234_5678, 32'd9, 1'b1, 5'd7, 0);
        applyStimulus(C_SRA, 32'h8000_0000, 32'd4, 1'b1, 5'd8, 0);
        idleCycles(8, 1'b1);
        applyStimulus(C_SLL, 32'h0000_0003, 32'd0, 1'b1, 5'd9, 0);

        // Backpressure: second beat waits with out_ready low, then both
        // drain and accept happen in one cycle.
        applyStimulus(C_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 5'd10, 0);
        applyStimulus(C_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 5'd11, 3);
        idleCycles(3, 1'b1);

        // Long shift aborted by reset.
        applyStimulus(C_SLL, 32'd1, 32'd31, 1'b1, 5'd12, 0);
        idleCycles(9, 1'b1);
        pulseReset();
        idleCycles(2, 1'b1);

        randomReady = 1'b1;
        for (int n = 0; n < 300; n++) begin
            o  = 5'($urandom_range(0, 15));
            a  = randData();
            b  = randData();
            w  = 1'($urandom_range(0, 1));
            ad = 5'($urandom_range(0, 31));
            applyStimulus(o, a, b, w, ad, 0);
            if ($urandom_range(0, 3) == 0) idleCycles(1, 1'($urandom_range(0, 1)));
        end

        k = 0;
        while (sbq.size() > 0 && k < 300) begin
            idleCycles(1, 1'b1);
            k++;
        end
        idleCycles(1, 1'b1);
        checkOutput("drain_pending", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
